// File: rtl/test_i2022_pkg.sv
`default_nettype none
//==============================================================================
// test_i2022_pkg : shared state encoding and trigger pattern constants
// Revision 1.0
//==============================================================================
package test_i2022_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S1    = 2'd1,
    S2    = 2'd2,
    ARMED = 2'd3
  } trig_state_e;

  localparam logic [2:0] TRIG_A     = 3'b000;
  localparam logic [2:0] TRIG_B     = 3'b101;
  localparam logic [2:0] TRIG_C     = 3'b111;
  localparam int         ARM_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/i2022_trigger_fsm.sv
`default_nettype none
//==============================================================================
// i2022_trigger_fsm : 000/101/111 sequence detector arming a 4-cycle payload
// Revision 1.0
//==============================================================================
module i2022_trigger_fsm
  import test_i2022_pkg::*;
(
  input  logic       CK,
  input  logic       reset,
  input  logic [2:0] n_q,
  output logic       p
);

  localparam logic [1:0] CNT_LAST = 2'(ARM_CYCLES - 1);

  trig_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        p_q, p_d;

  // A 000 sample in S1/S2 restarts the sequence rather than aborting it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (n_q == TRIG_A) state_d = S1;
      end
      S1: begin
        if (n_q == TRIG_B)      state_d = S2;
        else if (n_q == TRIG_A) state_d = S1;
        else                    state_d = IDLE;
      end
      S2: begin
        if (n_q == TRIG_C) begin
          state_d = ARMED;
          cnt_d   = 2'd0;
        end else if (n_q == TRIG_A) begin
          state_d = S1;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (cnt_q == CNT_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
    p_d = (state_d == ARMED);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign p = p_q;

endmodule
`default_nettype wire

// File: rtl/test_i2022.sv
`default_nettype none
//==============================================================================
// test_i2022 : registered 3-input parity-style function with trigger payload
// Revision 1.0
//==============================================================================
module test_i2022
  import test_i2022_pkg::*;
(
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic CK,
  input  logic reset,
  output logic Z
);

  logic [2:0] n_q, n_d;
  logic       f;
  logic       p;

  always_comb begin
    n_d = {N0, N1, N2};
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) n_q <= 3'b000;
    else        n_q <= n_d;
  end

  // n_q[2] holds N0, n_q[1] holds N1, n_q[0] holds N2.
  assign f = n_q[2] ^ (n_q[1] & n_q[0]);

  i2022_trigger_fsm u_trigger_fsm (
    .CK    (CK),
    .reset (reset),
    .n_q   (n_q),
    .p     (p)
  );

  assign Z = f ^ p;

endmodule
`default_nettype wire

// File: tb/tb_test_i2022.sv
`default_nettype none
//==============================================================================
// tb_test_i2022 : scoreboard bench for test_i2022
// Revision 1.0
//==============================================================================
module tb_test_i2022;

  logic N0, N1, N2, CK, reset;
  logic Z;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [2:0] m_n;
  int         m_st;
  int         m_cnt;
  logic       exp_q[$];

  test_i2022 dut (
    .N0    (N0),
    .N1    (N1),
    .N2    (N2),
    .CK    (CK),
    .reset (reset),
    .Z     (Z)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_n   = 3'b000;
    m_st  = 0;
    m_cnt = 0;
  endfunction

  function automatic logic model_z();
    return (m_n[2] ^ (m_n[1] & m_n[0])) ^ (m_st == 3);
  endfunction

  // advance the model by one rising edge with input v ({N0,N1,N2})
  function automatic void model_step(input logic [2:0] v);
    case (m_st)
      0: if (m_n == 3'b000) m_st = 1;
      1: m_st = (m_n == 3'b101) ? 2 : (m_n == 3'b000) ? 1 : 0;
      2: begin
        if (m_n == 3'b111) begin m_st = 3; m_cnt = 0; end
        else m_st = (m_n == 3'b000) ? 1 : 0;
      end
      default: begin
        if (m_cnt == 3) m_st = 0;
        else m_cnt = m_cnt + 1;
      end
    endcase
    m_n = v;
  endfunction

  task automatic drive(input logic [2:0] v, input string tag);
    {N0, N1, N2} = v;
    model_step(v);
    exp_q.push_back(model_z());
    @(posedge CK);
    #1;
    if (exp_q.size() == 0) chk({tag, "_empty"}, Z, 1'bx);
    else                   chk(tag, Z, exp_q.pop_front());
  endtask

  task automatic drive_seq(input logic [2:0] seq[$], input string tag);
    foreach (seq[i]) drive(seq[i], tag);
  endtask

  logic [2:0] sq[$];
  logic       sweep_tbl [8];
  int         ones;

  initial begin
    sweep_tbl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b0;
    {N0, N1, N2} = 3'b111;
    model_reset();

    // reset held with active inputs
    #2;
    chk("rst_init", Z, 1'b0);
    for (int i = 0; i < 3; i++) begin
      {N0, N1, N2} = 3'($urandom_range(0, 7));
      @(posedge CK);
      #1;
      chk("rst_hold", Z, 1'b0);
    end
    @(negedge CK);
    reset = 1'b1;

    // exhaustive sweep from IDLE, against the fixed truth table too
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), "sweep_sb");
      chk("sweep_tbl", Z, sweep_tbl[i]);
    end

    // trigger, then hold 000: exactly four inverted cycles
    ones = 0;
    sq = '{3'b000, 3'b101, 3'b111};
    drive_seq(sq, "trig");
    for (int i = 0; i < 6; i++) begin
      drive(3'b000, "trig_hold");
      if (Z) ones++;
    end
    chk("trig_ones_eq4", 1'(ones == 4), 1'b1);

    // payload ignores a repeated pattern while armed
    sq = '{3'b000, 3'b101, 3'b111, 3'b000, 3'b101, 3'b111,
           3'b000, 3'b000, 3'b000, 3'b000};
    drive_seq(sq, "ignore");

    // broken sequence stays non-armed
    sq = '{3'b000, 3'b101, 3'b110};
    drive_seq(sq, "broken");
    chk("broken_110", Z, 1'b1);
    drive(3'b000, "broken_tail");
    drive(3'b000, "broken_tail");

    // restart overlap
    sq = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b101, 3'b111,
           3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    drive_seq(sq, "overlap");

    // random traffic
    for (int i = 0; i < 40; i++) drive(3'($urandom_range(0, 7)), "rand");

    // async reset in the middle of ARMED
    sq = '{3'b000, 3'b101, 3'b111, 3'b000};
    drive_seq(sq, "pre_rst");
    chk("armed_before_rst", Z, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", Z, 1'b0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      {N0, N1, N2} = 3'b100;
      @(posedge CK);
      #1;
      chk("rst_mid_hold", Z, 1'b0);
    end
    @(negedge CK);
    reset = 1'b1;
    sq = '{3'b100, 3'b000, 3'b101, 3'b111, 3'b000, 3'b000,
           3'b000, 3'b000, 3'b000};
    drive_seq(sq, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
